// File: rtl/mem_responder.sv
// Data-memory responder for the MEM stage: word storage behind a fixed number of
// wait states, with a one-cycle Ready/Err completion strobe.
module mem_responder #(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] Addr,
    input  logic [31:0] Val_Rm,
    output logic [31:0] Rdata,
    output logic        Ready,
    output logic        Err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        lat_r, lat_w;
    logic [31:0] lat_addr, lat_data;
    logic [31:0] mem [DEPTH];

    logic        req;
    logic        acc_r, acc_w, acc_go, acc_err;
    logic [31:0] acc_addr, acc_data, word_off;

    assign req = MEM_R_EN | MEM_W_EN;

    // With zero wait states the access happens on the accept edge, so use the live inputs.
    assign acc_r    = (state == IDLE) ? MEM_R_EN : lat_r;
    assign acc_w    = (state == IDLE) ? MEM_W_EN : lat_w;
    assign acc_addr = (state == IDLE) ? Addr     : lat_addr;
    assign acc_data = (state == IDLE) ? Val_Rm   : lat_data;
    assign acc_go   = (state_nxt == DONE) && (state != DONE);

    assign word_off = (acc_addr - BASE_ADDR) >> 2;
    assign acc_err  = (acc_r & acc_w) | (|acc_addr[1:0]) | (acc_addr < BASE_ADDR)
                    | (word_off >= 32'(DEPTH));

    always_comb begin
        state_nxt = state;
        Ready     = 1'b0;
        case (state)
            IDLE: begin
                Ready = ~req;
                if (req) state_nxt = (WAIT_CYCLES == 0) ? DONE : BUSY;
            end
            BUSY: begin
                if (cnt == 4'd1) state_nxt = DONE;
            end
            DONE: begin
                Ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_r    <= 1'b0;
            lat_w    <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            Rdata    <= '0;
            Err      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req) begin
                    lat_r    <= MEM_R_EN;
                    lat_w    <= MEM_W_EN;
                    lat_addr <= Addr;
                    lat_data <= Val_Rm;
                    cnt      <= 4'(WAIT_CYCLES);
                end
                BUSY:    cnt <= cnt - 4'd1;
                DONE:    Err <= 1'b0;
                default: ;
            endcase
            if (acc_go) begin
                if (acc_err) begin
                    Rdata <= '0;
                    Err   <= 1'b1;
                end else if (acc_r) begin
                    Rdata <= mem[word_off[AW-1:0]];
                end
            end
        end
    end

    // Storage is never cleared; reset only suppresses a write due on the same edge.
    always_ff @(posedge CLK) begin
        if (RST && acc_go && !acc_err && acc_w)
            mem[word_off[AW-1:0]] <= acc_data;
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with 2 wait states, one with none, checked
// against a word-array model of the storage and the expected Ready timing.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        r_en  [2];
    logic        w_en  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        err   [2];

    int          waits [2] = '{2, 0};
    logic [31:0] mem_m [2][64];
    logic [31:0] rd_m  [2];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) u_w2 (
        .CLK(clk), .RST(rst_n), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
        .Addr(addr[0]), .Val_Rm(wdata[0]), .Rdata(rdata[0]), .Ready(ready[0]), .Err(err[0])
    );

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) u_w0 (
        .CLK(clk), .RST(rst_n), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
        .Addr(addr[1]), .Val_Rm(wdata[1]), .Rdata(rdata[1]), .Ready(ready[1]), .Err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on DUT d, issued at the start of the current cycle and held until Ready.
    task automatic access(input int d, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] v);
        bit e;
        int idx;
        r_en[d] = r; w_en[d] = w; addr[d] = a; wdata[d] = v;
        e = (r && w) || (a[1:0] != 2'b00) || (a < 32'd1024) || (((a - 32'd1024) >> 2) >= 32'd64);
        if (e) rd_m[d] = '0;
        else begin
            idx = int'((a - 32'd1024) >> 2);
            if (w) mem_m[d][idx] = v;
            else   rd_m[d] = mem_m[d][idx];
        end
        for (int k = 0; k <= waits[d] + 1; k++) begin
            @(negedge clk);
            chk($sformatf("ready d%0d a=%h k=%0d", d, a, k), 32'(ready[d]), 32'(k == waits[d] + 1));
            chk($sformatf("err d%0d a=%h k=%0d", d, a, k), 32'(err[d]),
                (k == waits[d] + 1) ? 32'(e) : 32'd0);
            if (k == waits[d] + 1)
                chk($sformatf("rdata d%0d a=%h", d, a), rdata[d], rd_m[d]);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int d);
        r_en[d] = 1'b0; w_en[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("idle ready d%0d", d), 32'(ready[d]), 32'd1);
        chk($sformatf("idle err d%0d", d), 32'(err[d]), 32'd0);
        chk($sformatf("idle rdata d%0d", d), rdata[d], rd_m[d]);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            r_en[d] = 1'b0; w_en[d] = 1'b0; addr[d] = '0; wdata[d] = '0; rd_m[d] = '0;
        end
        rst_n = 1'b0;

        // Reset then idle
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rst ready d%0d", d), 32'(ready[d]), 32'd1);
                chk($sformatf("rst rdata d%0d", d), rdata[d], 32'd0);
                chk($sformatf("rst err d%0d", d), 32'(err[d]), 32'd0);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin idle(0); idle(1); end

        // Fill every word so later reads have defined contents
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++)
                access(d, 1'b0, 1'b1, 32'd1024 + 32'(4 * i), $urandom);
        idle(0); idle(1);

        // Directed cases, two wait states
        access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        access(0, 1'b0, 1'b1, 32'd1024 + 32'd252, 32'h12345678);
        access(0, 1'b1, 1'b0, 32'd1024 + 32'd252, 32'h0);
        access(0, 1'b1, 1'b0, 32'd1024 + 32'd256, 32'h0);
        access(0, 1'b0, 1'b1, 32'd1024 + 32'd256, 32'h55555555);
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        access(0, 1'b1, 1'b0, 32'd1026, 32'h0);
        access(0, 1'b0, 1'b1, 32'd1026, 32'h11111111);
        access(0, 1'b1, 1'b0, 32'd1020, 32'h0);
        access(0, 1'b0, 1'b1, 32'd1020, 32'h22222222);
        access(0, 1'b1, 1'b1, 32'd1024, 32'h33333333);
        access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
        idle(0);

        // Reset lands on the edge that would have performed the write
        r_en[0] = 1'b0; w_en[0] = 1'b1; addr[0] = 32'd1028; wdata[0] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0; w_en[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_m[0] = '0; rd_m[1] = '0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst ready d%0d", d), 32'(ready[d]), 32'd1);
            chk($sformatf("midrst rdata d%0d", d), rdata[d], 32'd0);
            chk($sformatf("midrst err d%0d", d), 32'(err[d]), 32'd0);
        end
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
        idle(0);

        // Zero wait states, request held continuously
        for (int i = 0; i < 6; i++) access(1, 1'b1, 1'b0, 32'd1044, 32'h0);
        for (int i = 0; i < 6; i++) access(1, 1'b1, 1'b0, 32'd1024 + 32'(4 * i), 32'h0);
        access(1, 1'b0, 1'b1, 32'd1044, 32'hCAFEF00D);
        access(1, 1'b1, 1'b0, 32'd1044, 32'h0);
        access(1, 1'b1, 1'b0, 32'd1024 + 32'd256, 32'h0);
        idle(1);

        // Random traffic on both instances
        for (int n = 0; n < 300; n++) begin
            int d, sel, op;
            logic [31:0] a;
            d   = n % 2;
            sel = $urandom_range(0, 9);
            op  = $urandom_range(0, 8);
            if (sel < 7)       a = 32'd1024 + 32'(4 * $urandom_range(0, 63));
            else if (sel == 7) a = 32'd1024 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'($urandom_range(0, 255)) << 2;
            else               a = 32'd1280 + 32'(4 * $urandom_range(0, 100));
            access(d, op < 4 || op == 8, op >= 4, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(d);
            else begin r_en[d] = 1'b0; w_en[d] = 1'b0; end
        end
        idle(0); idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
